umem_arbiter: RTL and testbench



---
 rtl/umem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_umem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/umem_arbiter.sv
// -----------------------------------------------------------------------------
// umem_arbiter
//
// Shares one single-port unified memory between the instruction fetch port (I,
// read-only) and the memory-access stage port (D, load/store). One access is
// in flight at a time. D normally wins a simultaneous request, but after
// MAX_DWIN consecutive D wins over a waiting fetch, the fetch is forced through.
//
// Parameters
//   LAT       memory access cycles (>= 1); M_RDATA is valid in the last one
//   MAX_DWIN  consecutive D wins over a pending I before I is forced (>= 1)
//
// Ports
//   CLK, RST                      clock, synchronous active-high reset
//   I_REQ/I_ADDR                  fetch request (held until I_ACK) and address
//   I_ACK/I_RDATA                 one-cycle completion pulse and fetch data
//   D_REQ/D_WE/D_ADDR/D_WDATA     data request (held until D_ACK), store flag,
//                                 address and store data
//   D_ACK/D_RDATA                 one-cycle completion pulse and load data
//   M_EN/M_WE/M_ADDR/M_WDATA      memory strobe, write strobe, address, data
//   M_RDATA                       memory read data
//   I_GRANTS/D_GRANTS/CONFLICTS   wrapping 32-bit performance counters
//
// Sequence: IDLE (decision) -> ACCESS (LAT cycles) -> RESP (ACK) -> IDLE, so a
// request seen in IDLE at cycle t is acknowledged at cycle t+LAT+1. Every
// output is decoded from state or from registers; no REQ reaches M_* directly.
// -----------------------------------------------------------------------------
module umem_arbiter #(
    parameter int unsigned LAT      = 1,
    parameter int unsigned MAX_DWIN = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        I_REQ,
    input  logic [31:0] I_ADDR,
    output logic        I_ACK,
    output logic [31:0] I_RDATA,
    input  logic        D_REQ,
    input  logic        D_WE,
    input  logic [31:0] D_ADDR,
    input  logic [31:0] D_WDATA,
    output logic        D_ACK,
    output logic [31:0] D_RDATA,
    output logic        M_EN,
    output logic        M_WE,
    output logic [31:0] M_ADDR,
    output logic [31:0] M_WDATA,
    input  logic [31:0] M_RDATA,
    output logic [31:0] I_GRANTS,
    output logic [31:0] D_GRANTS,
    output logic [31:0] CONFLICTS
);

    localparam int unsigned   CW         = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int unsigned   SW         = $clog2(MAX_DWIN + 1);
    localparam logic [CW-1:0] CNT_INIT   = CW'(LAT - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_DWIN);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          decide;      // a grant decision is made this cycle
    logic          grant_d;     // that decision goes to D
    logic          capture;     // last ACCESS cycle: M_RDATA is valid

    logic          owner_d;     // current/last access belongs to D
    logic          we_q;
    logic          first_q;     // high during the first ACCESS cycle only
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [CW-1:0] cnt;
    logic [SW-1:0] starve;      // consecutive D wins over a waiting fetch
    logic [31:0]   i_rdata_q;
    logic [31:0]   d_rdata_q;
    logic [31:0]   i_grants_q;
    logic [31:0]   d_grants_q;
    logic [31:0]   conflicts_q;

    // NOTE: every clocked assignment uses <= so all registers sample the
    // pre-edge values together, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: each signal gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        decide    = 1'b0;
        grant_d   = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (I_REQ || D_REQ) begin
                    decide    = 1'b1;
                    // D has priority unless a waiting fetch has been
                    // passed over MAX_DWIN times in a row.
                    grant_d   = D_REQ && !(I_REQ && (starve == STARVE_MAX));
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the data registers are reset as well as the control state,
    // because they drive outputs that must read zero straight after reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            owner_d     <= 1'b0;
            we_q        <= 1'b0;
            first_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt         <= '0;
            starve      <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_grants_q  <= '0;
            d_grants_q  <= '0;
            conflicts_q <= '0;
        end else begin
            first_q <= decide;

            if (decide) begin
                owner_d <= grant_d;
                addr_q  <= grant_d ? D_ADDR : I_ADDR;
                we_q    <= grant_d & D_WE;
                wdata_q <= grant_d ? D_WDATA : '0;
                cnt     <= CNT_INIT;

                if (grant_d && I_REQ) begin
                    if (starve != STARVE_MAX) begin
                        starve <= starve + SW'(1);
                    end
                end else begin
                    starve <= '0;
                end

                if (grant_d) begin
                    d_grants_q <= d_grants_q + 32'd1;
                end else begin
                    i_grants_q <= i_grants_q + 32'd1;
                end
                if (I_REQ && D_REQ) begin
                    conflicts_q <= conflicts_q + 32'd1;
                end
            end else if ((state == ACCESS) && (cnt != '0)) begin
                cnt <= cnt - CW'(1);
            end

            // Stores also refresh D_RDATA; consumers simply ignore it.
            if (capture) begin
                if (owner_d) begin
                    d_rdata_q <= M_RDATA;
                end else begin
                    i_rdata_q <= M_RDATA;
                end
            end
        end
    end

    assign M_EN      = (state == ACCESS);
    // The write strobe is limited to the first cycle so a multi-cycle access
    // commits the store exactly once.
    assign M_WE      = (state == ACCESS) && we_q && first_q;
    assign M_ADDR    = addr_q;
    assign M_WDATA   = wdata_q;

    assign I_ACK     = (state == RESP) && !owner_d;
    assign D_ACK     = (state == RESP) && owner_d;
    assign I_RDATA   = i_rdata_q;
    assign D_RDATA   = d_rdata_q;

    assign I_GRANTS  = i_grants_q;
    assign D_GRANTS  = d_grants_q;
    assign CONFLICTS = conflicts_q;

endmodule

// File: tb/tb_umem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_umem_arbiter
//
// Two arbiters share the clock: u_a with LAT=1 and u_b with LAT=3, both with
// MAX_DWIN=4. Each sees a behavioural memory whose read data is a fixed
// function of the address. Every request pushes the expected (owner, data)
// pair onto that instance's queue; a negedge monitor pops and compares on
// each ACK, and any ACK with an empty queue is reported.
// -----------------------------------------------------------------------------
module tb_umem_arbiter;

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_mis = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];
    logic [9:0] d_order;

    logic        a_rst, a_i_req, a_d_req, a_d_we;
    logic [31:0] a_i_addr, a_d_addr, a_d_wdata;
    logic        a_i_ack, a_d_ack, a_m_en, a_m_we;
    logic [31:0] a_i_rdata, a_d_rdata, a_m_addr, a_m_wdata, a_m_rdata;
    logic [31:0] a_i_grants, a_d_grants, a_conflicts;

    logic        b_rst, b_i_req, b_d_req, b_d_we;
    logic [31:0] b_i_addr, b_d_addr, b_d_wdata;
    logic        b_i_ack, b_d_ack, b_m_en, b_m_we;
    logic [31:0] b_i_rdata, b_d_rdata, b_m_addr, b_m_wdata, b_m_rdata;
    logic [31:0] b_i_grants, b_d_grants, b_conflicts;

    function automatic logic [31:0] mem_val(input logic [31:0] addr);
        return (addr == 32'h10) ? 32'hDEAD_BEEF : ((addr ^ 32'h5A5A_0000) + 32'h0000_0101);
    endfunction

    function automatic exp_t mk(input logic is_d, input logic [31:0] data);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        return e;
    endfunction

    assign a_m_rdata = mem_val(a_m_addr);
    assign b_m_rdata = mem_val(b_m_addr);

    umem_arbiter #(.LAT(1), .MAX_DWIN(4)) u_a (
        .CLK(clk), .RST(a_rst),
        .I_REQ(a_i_req), .I_ADDR(a_i_addr), .I_ACK(a_i_ack), .I_RDATA(a_i_rdata),
        .D_REQ(a_d_req), .D_WE(a_d_we), .D_ADDR(a_d_addr), .D_WDATA(a_d_wdata),
        .D_ACK(a_d_ack), .D_RDATA(a_d_rdata),
        .M_EN(a_m_en), .M_WE(a_m_we), .M_ADDR(a_m_addr), .M_WDATA(a_m_wdata),
        .M_RDATA(a_m_rdata),
        .I_GRANTS(a_i_grants), .D_GRANTS(a_d_grants), .CONFLICTS(a_conflicts)
    );

    umem_arbiter #(.LAT(3), .MAX_DWIN(4)) u_b (
        .CLK(clk), .RST(b_rst),
        .I_REQ(b_i_req), .I_ADDR(b_i_addr), .I_ACK(b_i_ack), .I_RDATA(b_i_rdata),
        .D_REQ(b_d_req), .D_WE(b_d_we), .D_ADDR(b_d_addr), .D_WDATA(b_d_wdata),
        .D_ACK(b_d_ack), .D_RDATA(b_d_rdata),
        .M_EN(b_m_en), .M_WE(b_m_we), .M_ADDR(b_m_addr), .M_WDATA(b_m_wdata),
        .M_RDATA(b_m_rdata),
        .I_GRANTS(b_i_grants), .D_GRANTS(b_d_grants), .CONFLICTS(b_conflicts)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns on the negedge of the n-th ACK from u_a, or after a cycle budget.
    task automatic wait_acks_a(input int n, input string tag);
        int seen = 0;
        for (int cyc = 0; cyc < 200 && seen < n; cyc++) begin
            @(negedge clk);
            if (a_i_ack || a_d_ack) seen++;
        end
        check(tag, 32'(seen), 32'(n));
    endtask

    task automatic reset_a();
        a_rst   = 1'b1;
        a_i_req = 1'b0;
        a_d_req = 1'b0;
        step(2);
        a_rst   = 1'b0;
        sb_a.delete();
    endtask

    // Scoreboard monitors: owner code is {i_ack, d_ack}, so I=2, D=1.
    always @(negedge clk) begin
        exp_t e;
        if (a_i_ack || a_d_ack) begin
            if (sb_a.size() == 0) begin
                check("a_unexpected_ack", {30'd0, a_i_ack, a_d_ack}, 32'd0);
            end else begin
                e = sb_a.pop_front();
                check("a_ack_owner", {30'd0, a_i_ack, a_d_ack}, e.is_d ? 32'd1 : 32'd2);
                check("a_rdata", e.is_d ? a_d_rdata : a_i_rdata, e.data);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b_i_ack || b_d_ack) begin
            if (sb_b.size() == 0) begin
                check("b_unexpected_ack", {30'd0, b_i_ack, b_d_ack}, 32'd0);
            end else begin
                e = sb_b.pop_front();
                check("b_ack_owner", {30'd0, b_i_ack, b_d_ack}, e.is_d ? 32'd1 : 32'd2);
                check("b_rdata", e.is_d ? b_d_rdata : b_i_rdata, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_rst = 1'b1; a_i_req = 1'b0; a_d_req = 1'b0; a_d_we = 1'b0;
        a_i_addr = '0; a_d_addr = '0; a_d_wdata = '0;
        b_rst = 1'b1; b_i_req = 1'b0; b_d_req = 1'b0; b_d_we = 1'b0;
        b_i_addr = '0; b_d_addr = '0; b_d_wdata = '0;
        d_order = 10'b01111_01111;   // bit k = 1 when access k goes to D

        step(3);
        a_rst = 1'b0;
        b_rst = 1'b0;
        check("rst_a_m_en", 32'(a_m_en), 32'd0);
        check("rst_a_acks", {30'd0, a_i_ack, a_d_ack}, 32'd0);
        check("rst_a_i_grants", a_i_grants, 32'd0);
        check("rst_b_m_addr", b_m_addr, 32'd0);
        check("rst_b_d_grants", b_d_grants, 32'd0);

        // Single fetch, LAT=1.
        step(1);
        a_i_addr = 32'h10;
        a_i_req  = 1'b1;
        sb_a.push_back(mk(1'b0, 32'hDEAD_BEEF));
        step(1);
        check("t1_m_en_t1", 32'(a_m_en), 32'd1);
        check("t1_m_addr", a_m_addr, 32'h10);
        check("t1_m_we", 32'(a_m_we), 32'd0);
        check("t1_no_early_ack", 32'(a_i_ack), 32'd0);
        step(1);
        check("t1_i_ack_t2", 32'(a_i_ack), 32'd1);
        a_i_req = 1'b0;
        check("t1_i_grants", a_i_grants, 32'd1);
        check("t1_d_grants", a_d_grants, 32'd0);
        check("t1_conflicts", a_conflicts, 32'd0);
        step(1);
        check("t1_ack_one_cycle", 32'(a_i_ack), 32'd0);
        check("t1_m_en_idle", 32'(a_m_en), 32'd0);
        check("t1_rdata_hold", a_i_rdata, 32'hDEAD_BEEF);

        // Store, LAT=3: M_WE one cycle, M_EN three cycles, ACK at t+4.
        b_d_we    = 1'b1;
        b_d_addr  = 32'h40;
        b_d_wdata = 32'h1234;
        b_d_req   = 1'b1;
        sb_b.push_back(mk(1'b1, mem_val(32'h40)));
        for (int k = 1; k <= 4; k++) begin
            step(1);
            check($sformatf("t2_m_en_c%0d", k), 32'(b_m_en), 32'(k <= 3));
            check($sformatf("t2_m_we_c%0d", k), 32'(b_m_we), 32'(k == 1));
            check($sformatf("t2_d_ack_c%0d", k), 32'(b_d_ack), 32'(k == 4));
        end
        check("t2_m_addr", b_m_addr, 32'h40);
        check("t2_m_wdata", b_m_wdata, 32'h1234);
        check("t2_d_grants", b_d_grants, 32'd1);
        b_d_req = 1'b0;
        b_d_we  = 1'b0;

        // Both requests held: D,D,D,D,I,D,D,D,D,I.
        reset_a();
        a_i_addr = 32'h20;
        a_d_addr = 32'h30;
        a_d_we   = 1'b0;
        a_i_req  = 1'b1;
        a_d_req  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            sb_a.push_back(mk(d_order[k], d_order[k] ? mem_val(32'h30) : mem_val(32'h20)));
        end
        wait_acks_a(10, "t3_ten_acks");
        a_i_req = 1'b0;
        a_d_req = 1'b0;
        step(1);
        check("t3_conflicts", a_conflicts, 32'd10);
        check("t3_d_grants", a_d_grants, 32'd8);
        check("t3_i_grants", a_i_grants, 32'd2);
        check("t3_sb_drained", 32'(sb_a.size()), 32'd0);

        // Fetch drops during a D access, returns right after D_ACK.
        reset_a();
        a_i_req = 1'b1;
        a_d_req = 1'b1;
        sb_a.push_back(mk(1'b1, mem_val(32'h30)));
        step(1);
        check("t4_d_owns", a_m_addr, 32'h30);
        a_i_req = 1'b0;
        step(1);
        check("t4_d_ack", 32'(a_d_ack), 32'd1);
        a_d_req = 1'b0;
        step(1);
        check("t4_idle", 32'(a_m_en), 32'd0);
        a_i_req = 1'b1;
        sb_a.push_back(mk(1'b0, mem_val(32'h20)));
        step(1);
        check("t4_i_granted_addr", a_m_addr, 32'h20);
        check("t4_i_granted_en", 32'(a_m_en), 32'd1);
        step(1);
        check("t4_i_ack", 32'(a_i_ack), 32'd1);
        // A cleared starve counter gives four D wins before the next forced I.
        a_d_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sb_a.push_back(mk(d_order[k], d_order[k] ? mem_val(32'h30) : mem_val(32'h20)));
        end
        wait_acks_a(5, "t4_five_acks");
        a_i_req = 1'b0;
        a_d_req = 1'b0;
        step(1);
        check("t4_i_grants", a_i_grants, 32'd2);
        check("t4_d_grants", a_d_grants, 32'd5);
        check("t4_conflicts", a_conflicts, 32'd6);
        check("t4_sb_drained", 32'(sb_a.size()), 32'd0);

        // Reset in the second ACCESS cycle of a LAT=3 load.
        b_d_we   = 1'b0;
        b_d_addr = 32'h80;
        b_d_req  = 1'b1;
        step(1);
        check("t5_access1", 32'(b_m_en), 32'd1);
        step(1);
        check("t5_access2", 32'(b_m_en), 32'd1);
        b_rst   = 1'b1;
        b_d_req = 1'b0;
        step(1);
        b_rst = 1'b0;
        check("t5_m_en", 32'(b_m_en), 32'd0);
        check("t5_m_we", 32'(b_m_we), 32'd0);
        check("t5_m_addr", b_m_addr, 32'd0);
        check("t5_m_wdata", b_m_wdata, 32'd0);
        check("t5_acks", {30'd0, b_i_ack, b_d_ack}, 32'd0);
        check("t5_i_rdata", b_i_rdata, 32'd0);
        check("t5_d_rdata", b_d_rdata, 32'd0);
        check("t5_i_grants", b_i_grants, 32'd0);
        check("t5_d_grants", b_d_grants, 32'd0);
        check("t5_conflicts", b_conflicts, 32'd0);
        step(3);
        check("t5_no_late_ack", 32'(b_d_ack), 32'd0);
        b_i_addr = 32'h10;
        b_i_req  = 1'b1;
        sb_b.push_back(mk(1'b0, 32'hDEAD_BEEF));
        step(1);
        check("t5_new_access", 32'(b_m_en), 32'd1);
        step(3);
        check("t5_i_ack_lat", 32'(b_i_ack), 32'd1);
        b_i_req = 1'b0;
        step(1);
        check("t5_i_grants_after", b_i_grants, 32'd1);
        check("t5_sb_drained", 32'(sb_b.size()), 32'd0);

        // D_GRANTS wraps from all-ones to zero.
        force u_a.d_grants_q = 32'hFFFF_FFFF;
        step(1);
        release u_a.d_grants_q;
        step(1);
        check("t6_preset", a_d_grants, 32'hFFFF_FFFF);
        a_d_addr = 32'h30;
        a_d_we   = 1'b0;
        a_d_req  = 1'b1;
        sb_a.push_back(mk(1'b1, mem_val(32'h30)));
        wait_acks_a(1, "t6_ack");
        a_d_req = 1'b0;
        check("t6_wrap", a_d_grants, 32'd0);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
